// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer and the PC mux.
// The state encoding and PC select codes are reused by the PC register logic.
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    RUN       = 3'd1,
    LU_STALL  = 3'd2,
    REDIRECT  = 3'd3,
    IMEM_WAIT = 3'd4
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;

  localparam int LU_CNT_W = 3;

  // A jump wins when a taken branch and a jump resolve together.
  function automatic logic [1:0] redir_sel(input logic jump);
    return jump ? PC_SEL_JMP : PC_SEL_BR;
  endfunction

endpackage

// File: rtl/fetch_ctrl_hazard.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
// Register 0 never creates a hazard because it is hard-wired to zero.
module fetch_ctrl_hazard #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             hz_lu
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign hz_lu    = ex_mem_read && (ex_rt != '0) && (rs_match || rt_match);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: drives PC enable/select, IF/ID load/flush and ID/EX bubble.
// Optional FETCH_CTRL_PERF_EN adds saturating stall/redirect/wait counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_wait_cnt
`endif
);

  if (LU_CYCLES < 1 || LU_CYCLES > 7 || CNT_W < 1) begin : g_param_check
    $error("fetch_ctrl: LU_CYCLES must be 1..7 and CNT_W at least 1");
  end

  localparam logic [LU_CNT_W-1:0] LU_INIT = LU_CNT_W'(LU_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [LU_CNT_W-1:0] lu_cnt;
  logic [LU_CNT_W-1:0] lu_cnt_next;
  logic                hz_lu;
  logic                redir;

  fetch_ctrl_hazard #(
    .REG_W(REG_W)
  ) u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hz_lu       (hz_lu)
  );

  assign redir = ex_branch_taken || ex_jump;
  assign busy  = (state != RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BOOT;
      lu_cnt <= '0;
    end else begin
      state  <= state_next;
      lu_cnt <= lu_cnt_next;
    end
  end

  // Every redirect loads the PC together with an IF/ID flush, so no fetched
  // instruction is ever dropped while IF/ID is merely held.
  always_comb begin
    state_next  = state;
    lu_cnt_next = lu_cnt;
    pc_we       = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      BOOT: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if (redir) begin
          pc_we       = 1'b1;
          pc_sel      = redir_sel(ex_jump);
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_next  = REDIRECT;
        end else if (hz_lu) begin
          idex_bubble = 1'b1;
          lu_cnt_next = LU_INIT;
          state_next  = (LU_CYCLES > 1) ? LU_STALL : RUN;
        end else if (!imem_ready) begin
          ifid_flush = 1'b1;
          state_next = IMEM_WAIT;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      LU_STALL: begin
        if (redir) begin
          pc_we       = 1'b1;
          pc_sel      = redir_sel(ex_jump);
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          lu_cnt_next = '0;
          state_next  = REDIRECT;
        end else begin
          idex_bubble = 1'b1;
          lu_cnt_next = lu_cnt - LU_CNT_W'(1);
          if (lu_cnt == LU_CNT_W'(1)) state_next = RUN;
        end
      end
      REDIRECT, IMEM_WAIT: begin
        if (redir) begin
          pc_we       = 1'b1;
          pc_sel      = redir_sel(ex_jump);
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          state_next  = REDIRECT;
        end else if (imem_ready) begin
          pc_we      = 1'b1;
          ifid_we    = 1'b1;
          state_next = RUN;
        end else begin
          ifid_flush = 1'b1;
          state_next = IMEM_WAIT;
        end
      end
      default: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        state_next  = BOOT;
      end
    endcase
  end

`ifdef FETCH_CTRL_PERF_EN
  logic stall_cyc;
  logic redir_cyc;
  logic wait_cyc;

  assign stall_cyc = !redir && (((state == RUN) && hz_lu) || (state == LU_STALL));
  assign redir_cyc = redir && (state != BOOT);
  assign wait_cyc  = (state == IMEM_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_wait_cnt  <= '0;
    end else begin
      if (stall_cyc && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (redir_cyc && (perf_flush_cnt != '1)) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (wait_cyc && (perf_wait_cnt != '1))   perf_wait_cnt  <= perf_wait_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
